// File: rtl/jk_bank_pkg.sv
// Shared types and helpers for the JK bank arbiter: op encodings, the issue-register
// command struct, and the JK next-state rule.
package jk_bank_pkg;

    // Widest supported address and id (NFF <= 32, NREQ <= 8).
    localparam int unsigned MAX_AW = 5;
    localparam int unsigned MAX_IW = 3;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef struct packed {
        logic [1:0]        op;
        logic [MAX_AW-1:0] addr;
        logic [MAX_IW-1:0] id;
    } jk_cmd_t;

    function automatic logic jk_next(input logic cur, input logic [1:0] jk);
        logic nxt;
        nxt = cur;
        case (jk)
            OP_HOLD: nxt = cur;
            OP_RST:  nxt = 1'b0;
            OP_SET:  nxt = 1'b1;
            default: nxt = ~cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with asynchronous clear.
module jk_cell
    import jk_bank_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q, q_d;

    always_comb begin
        q_d = jk_next(q_q, {j, k});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of JK cells among several requesters; one command
// per cycle, completion reported two edges after the transfer.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned NFF  = 8,
    localparam int unsigned AW   = $clog2(NFF),
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [2*NREQ-1:0]  req_op,
    input  logic [AW*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    input  logic               freeze,
    output logic [NFF-1:0]     q,
    output logic               done_valid,
    output logic [IW-1:0]      done_id,
    output logic               done_q
);

    logic [NREQ-1:0] grant;
    logic            found;
    logic [IW-1:0]   winner;
    logic            transfer;

    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            issue_valid_q, issue_valid_d;
    jk_cmd_t         issue_cmd_q, issue_cmd_d;
    logic            done_valid_q, done_valid_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic            done_q_q, done_q_d;

    logic [AW-1:0]   issue_addr;
    logic [NFF-1:0]  cell_j, cell_k, cell_q;

    always_comb begin : p_arb
        int unsigned idx;
        grant  = '0;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned n = 0; n < NREQ; n++) begin
            idx = 32'(rr_ptr_q) + n;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && !freeze && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = IW'(idx);
            end
        end
    end

    // Grants are suppressed combinationally while reset is held.
    assign req_ready = grant & {NREQ{rst_n}};
    assign transfer  = found & rst_n;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            rr_ptr_d = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        issue_valid_d = transfer;
        issue_cmd_d   = issue_cmd_q;
        if (transfer) begin
            issue_cmd_d.op   = req_op[2*winner +: 2];
            issue_cmd_d.addr = MAX_AW'(req_addr[AW*winner +: AW]);
            issue_cmd_d.id   = MAX_IW'(winner);
        end
    end

    assign issue_addr = issue_cmd_q.addr[AW-1:0];

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        if (issue_valid_q) begin
            cell_j[issue_addr] = issue_cmd_q.op[1];
            cell_k[issue_addr] = issue_cmd_q.op[0];
        end
    end

    // done_q mirrors the value the addressed cell takes at the same edge.
    always_comb begin
        done_valid_d = issue_valid_q;
        done_id_d    = done_id_q;
        done_q_d     = done_q_q;
        if (issue_valid_q) begin
            done_id_d = issue_cmd_q.id[IW-1:0];
            done_q_d  = jk_next(cell_q[issue_addr], issue_cmd_q.op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_cmd_q   <= '0;
            done_valid_q  <= 1'b0;
            done_id_q     <= '0;
            done_q_q      <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_cmd_q   <= issue_cmd_d;
            done_valid_q  <= done_valid_d;
            done_id_q     <= done_id_d;
            done_q_q      <= done_q_d;
        end
    end

    for (genvar g = 0; g < NFF; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (cell_j[g]),
            .k     (cell_k[g]),
            .q     (cell_q[g])
        );
    end

    // Upper struct bits exist only for the widest configuration.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{issue_cmd_q.addr, issue_cmd_q.id};

    assign q          = cell_q;
    assign done_valid = done_valid_q;
    assign done_id    = done_id_q;
    assign done_q     = done_q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scenario-driven bench for jk_bank_arbiter with a completion scoreboard.
module tb_jk_bank_arbiter;

    localparam int NREQ = 4;
    localparam int NFF  = 8;
    localparam int AW   = 3;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [2*NREQ-1:0]  req_op = '0;
    logic [AW*NREQ-1:0] req_addr = '0;
    logic [NREQ-1:0]    req_ready;
    logic               freeze = 1'b0;
    logic [NFF-1:0]     q;
    logic               done_valid;
    logic [IW-1:0]      done_id;
    logic               done_q;

    jk_bank_arbiter #(
        .NREQ (NREQ),
        .NFF  (NFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .freeze     (freeze),
        .q          (q),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_q     (done_q)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0]  id;
        logic           val;
        logic [NFF-1:0] bank;
    } exp_t;

    exp_t           sb[$];
    logic [NFF-1:0] model = '0;
    int             checks = 0;
    int             errors = 0;

    function automatic logic model_next(input logic cur, input logic [1:0] op);
        case (op)
            2'b00:   return cur;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~cur;
        endcase
    endfunction

    // Predict at each transfer, compare at each completion.
    always @(negedge clk) begin : p_mon
        exp_t          e;
        logic [AW-1:0] a;
        logic [1:0]    op;
        if (rst_n) begin
            if (done_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done_id=%0d done_q=%0b, none outstanding",
                             done_id, done_q);
                end else begin
                    e = sb.pop_front();
                    if ({done_id, done_q, q} !== {e.id, e.val, e.bank}) begin
                        errors++;
                        $display("FAIL done_scoreboard: got id=%0d q=%0b bank=%h, want id=%0d q=%0b bank=%h",
                                 done_id, done_q, q, e.id, e.val, e.bank);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    a        = req_addr[AW*i +: AW];
                    op       = req_op[2*i +: 2];
                    model[a] = model_next(model[a], op);
                    e.id     = IW'(i);
                    e.val    = model[a];
                    e.bank   = model;
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [AW-1:0] addr);
        req_op[2*i +: 2]    = op;
        req_addr[AW*i +: AW] = addr;
        req_valid[i]         = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        freeze    = 1'b0;
        sb.delete();
        model = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if ({q, done_valid, done_id, done_q} !== {8'h00, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h dv=%b id=%0d dq=%b want all zero",
                     q, done_valid, done_id, done_q);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        set_req(0, 2'b10, 3'd3);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        step();
        checks++;
        if ({q, done_valid, done_id, done_q} !== {8'h08, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_done: got q=%h dv=%b id=%0d dq=%b want q=08 dv=1 id=0 dq=1",
                     q, done_valid, done_id, done_q);
        end
        step();
        checks++;
        if (done_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got done_valid=%b want 0", done_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_r;
        apply_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, 2'b11, AW'(k));
        for (int k = 0; k < NREQ; k++) begin
            #1;
            exp_r = '0;
            exp_r[k] = 1'b1;
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL rr_order_%0d: got %b want %b", k, req_ready, exp_r);
            end
            step();
            req_valid[k] = 1'b0;
        end
        step();
        checks++;
        if (q !== 8'h0F) begin
            errors++;
            $display("FAIL rr_bank: got %h want 0f", q);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_req(2, 2'b11, 3'd5);
        step();
        step();
        req_valid = '0;
        checks++;
        if ({q, done_id, done_q} !== {8'h20, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: got q=%h id=%0d dq=%b want q=20 id=2 dq=1", q, done_id, done_q);
        end
        step();
        checks++;
        if ({q, done_valid, done_q} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got q=%h dv=%b dq=%b want q=00 dv=1 dq=0",
                     q, done_valid, done_q);
        end
        step();
    endtask

    task automatic test_rr_pointer();
        apply_reset();
        set_req(1, 2'b00, 3'd0);
        step();
        set_req(1, 2'b11, 3'd1);
        set_req(3, 2'b11, 3'd3);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL ptr_first: got %b want 1000", req_ready);
        end
        step();
        req_valid[3] = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL ptr_second: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        for (int k = 0; k < NREQ; k++) set_req(k, 2'b00, 3'd0);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL ptr_after: got %b want 0100", req_ready);
        end
        req_valid = '0;
        repeat (3) step();
    endtask

    task automatic test_freeze();
        apply_reset();
        set_req(0, 2'b00, 3'd4);
        step();
        req_valid[0] = 1'b0;
        freeze       = 1'b1;
        set_req(1, 2'b10, 3'd6);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL freeze_ready0: got %b want 0000", req_ready);
        end
        step();
        checks++;
        if ({done_valid, done_id, done_q, req_ready} !== {1'b1, 2'd0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL freeze_inflight: got dv=%b id=%0d dq=%b ready=%b want dv=1 id=0 dq=0 ready=0000",
                     done_valid, done_id, done_q, req_ready);
        end
        freeze = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL freeze_release: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        repeat (2) step();
        checks++;
        if (q !== 8'h40) begin
            errors++;
            $display("FAIL freeze_bank: got %h want 40", q);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(0, 2'b10, 3'd2);
        step();
        req_valid = '0;
        repeat (2) step();
        checks++;
        if (q !== 8'h04) begin
            errors++;
            $display("FAIL mid_setup: got %h want 04", q);
        end
        set_req(0, 2'b10, 3'd7);
        step();
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        sb.delete();
        model = '0;
        #1;
        checks++;
        if ({q, done_valid} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_async_clear: got q=%h dv=%b want q=00 dv=0", q, done_valid);
        end
        step();
        checks++;
        if ({q, done_valid} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_dropped: got q=%h dv=%b want q=00 dv=0", q, done_valid);
        end
        rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, 2'b00, 3'd0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr_reset: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_rr_pointer();
        test_freeze();
        test_reset_mid();
        repeat (4) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL outstanding: got %0d completions missing want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
